// File: rtl/clock_cmd_parser.sv
// ASCII command front-end for the digital clock: parses "code field field ..." lines into set/alarm/mode updates.
// Optional macro CMD_RANGE_CHECK_EN enables calendar/time range and leap-year checks.
module clock_cmd_parser #(
    parameter int YEAR_BASE  = 2000,
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [1:0]  mode,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_min,
    output logic [5:0]  set_sec,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [11:0] set_year,
    output logic        set_load,
    output logic [10:0] alarm_min,
    output logic        alarm_load,
    output logic        cmd_err
);
    localparam int DW = $clog2(MAX_DIGITS + 2);

    typedef enum logic [2:0] {S_IDLE, S_CODE, S_GAP, S_FIELD, S_ERR, S_CHECK} state_t;

    state_t         r_state;
    logic [2:0]     r_code;
    logic [2:0]     r_count;
    logic [DW-1:0]  r_digits;
    logic [13:0]    r_acc;
    logic [13:0]    r_field [0:5];
    logic           r_err;

    logic           w_xfer, w_digit, w_space, w_term, w_code_digit;
    logic [13:0]    w_acc_next, w_year_raw;
    logic [11:0]    w_year;
    logic           w_range_en, w_range_ok, w_year_ok;
    logic           w_set_ok, w_alarm_ok, w_mode_ok;

    function automatic logic is_leap(input logic [11:0] y);
        return ((y % 12'd4 == 12'd0) && (y % 12'd100 != 12'd0)) || (y % 12'd400 == 12'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
        case (m)
            4'd2:                       return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:    return 5'd30;
            default:                    return 5'd31;
        endcase
    endfunction

    assign w_xfer       = rx_valid && rx_ready;
    assign w_digit      = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_code_digit = (rx_data >= 8'h31) && (rx_data <= 8'h34);
    assign w_space      = (rx_data == 8'h20);
    assign w_term       = (rx_data == 8'h0A) || (rx_data == 8'h0D);
    assign w_acc_next   = 14'(r_acc * 14'd10) + {10'd0, rx_data[3:0]};

`ifdef CMD_RANGE_CHECK_EN
    assign w_range_en = 1'b1;
`else
    assign w_range_en = 1'b0;
`endif

    // Command acceptance rules, evaluated from the stored fields while in CHECK
    always_comb begin
        w_year_raw = r_field[5];
        if (r_field[5] < 14'd100) begin
            w_year_raw = r_field[5] + 14'(YEAR_BASE);
        end else begin
            w_year_raw = r_field[5];
        end
        w_year_ok  = (w_year_raw < 14'd4096);
        w_year     = w_year_raw[11:0];
        w_range_ok = (r_field[0] < 14'd24) && (r_field[1] < 14'd60) && (r_field[2] < 14'd60) &&
                     (r_field[4] >= 14'd1) && (r_field[4] <= 14'd12) && (r_field[3] >= 14'd1) &&
                     (r_field[3] <= {9'd0, days_in_month(r_field[4][3:0], w_year)});
        w_set_ok   = !r_err && (r_code == 3'd3) && (r_count == 3'd6) && w_year_ok &&
                     (!w_range_en || w_range_ok);
        w_alarm_ok = !r_err && (r_code == 3'd4) && (r_count == 3'd1) &&
                     (!w_range_en || (r_field[0] < 14'd1440));
        w_mode_ok  = !r_err && ((r_code == 3'd1) || (r_code == 3'd2)) && (r_count == 3'd0);
    end

    // Byte-level parser FSM with registered outputs and pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_code     <= 3'd0;
            r_count    <= 3'd0;
            r_digits   <= '0;
            r_acc      <= 14'd0;
            r_err      <= 1'b0;
            for (int i = 0; i < 6; i++) r_field[i] <= 14'd0;
            rx_ready   <= 1'b1;
            mode       <= 2'd1;
            set_hour   <= 5'd0;
            set_min    <= 6'd0;
            set_sec    <= 6'd0;
            set_day    <= 5'd1;
            set_month  <= 4'd1;
            set_year   <= 12'd2020;
            alarm_min  <= 11'd0;
            set_load   <= 1'b0;
            alarm_load <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            set_load   <= 1'b0;
            alarm_load <= 1'b0;
            cmd_err    <= 1'b0;
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    if (w_space || w_term) begin
                        r_state <= S_IDLE;
                    end else if (w_code_digit) begin
                        r_code  <= rx_data[2:0];
                        r_count <= 3'd0;
                        r_state <= S_CODE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_CODE: if (w_xfer) begin
                    if (w_space) begin
                        r_state <= S_GAP;
                    end else if (w_term) begin
                        rx_ready <= 1'b0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_GAP: if (w_xfer) begin
                    if (w_digit) begin
                        r_acc    <= {10'd0, rx_data[3:0]};
                        r_digits <= DW'(1);
                        if (r_count != 3'd7) r_count <= r_count + 3'd1;
                        r_state  <= S_FIELD;
                    end else if (w_term) begin
                        rx_ready <= 1'b0;
                        r_state  <= S_CHECK;
                    end else if (!w_space) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_FIELD: if (w_xfer) begin
                    if (w_digit && (r_digits != DW'(MAX_DIGITS))) begin
                        r_acc    <= w_acc_next;
                        r_digits <= r_digits + DW'(1);
                    end else if (w_space || w_term) begin
                        // Only the first six fields are kept; a seventh just fails the count check
                        if (r_count <= 3'd6) r_field[r_count - 3'd1] <= r_acc;
                        rx_ready <= !w_term;
                        r_state  <= w_term ? S_CHECK : S_GAP;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: if (w_xfer && w_term) begin
                    rx_ready <= 1'b0;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    rx_ready <= 1'b1;
                    r_err    <= 1'b0;
                    r_state  <= S_IDLE;
                    if (w_mode_ok) begin
                        mode <= r_code[1:0];
                    end else if (w_set_ok) begin
                        set_hour  <= r_field[0][4:0];
                        set_min   <= r_field[1][5:0];
                        set_sec   <= r_field[2][5:0];
                        set_day   <= r_field[3][4:0];
                        set_month <= r_field[4][3:0];
                        set_year  <= w_year;
                        set_load  <= 1'b1;
                    end else if (w_alarm_ok) begin
                        alarm_min  <= r_field[0][10:0];
                        alarm_load <= 1'b1;
                    end else begin
                        cmd_err <= 1'b1;
                    end
                end
                default: begin
                    rx_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clock_cmd_parser.sv
// Directed self-checking bench for clock_cmd_parser; expectations follow CMD_RANGE_CHECK_EN when defined.
module tb_clock_cmd_parser;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [1:0]  mode;
    logic [4:0]  set_hour;
    logic [5:0]  set_min;
    logic [5:0]  set_sec;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [11:0] set_year;
    logic        set_load;
    logic [10:0] alarm_min;
    logic        alarm_load;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;
    int n_set = 0, n_alarm = 0, n_err = 0, n_nr = 0;

    clock_cmd_parser dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mode(mode), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_day(set_day), .set_month(set_month), .set_year(set_year), .set_load(set_load),
        .alarm_min(alarm_min), .alarm_load(alarm_load), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Pulse and not-ready cycle counters, sampled on the inactive edge
    always @(negedge clk) begin
        if (set_load === 1'b1) n_set++;
        if (alarm_load === 1'b1) n_alarm++;
        if (cmd_err === 1'b1) n_err++;
        if (rx_ready === 1'b0) n_nr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        @(negedge clk);
        n_set = 0; n_alarm = 0; n_err = 0; n_nr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) check("ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int es, input int ea, input int ee);
        check({tag, "_set_load"}, 32'(n_set), 32'(es));
        check({tag, "_alarm_load"}, 32'(n_alarm), 32'(ea));
        check({tag, "_cmd_err"}, 32'(n_err), 32'(ee));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, 32'(mode), 32'd1);
        check({tag, "_hour"}, 32'(set_hour), 32'd0);
        check({tag, "_min"}, 32'(set_min), 32'd0);
        check({tag, "_sec"}, 32'(set_sec), 32'd0);
        check({tag, "_day"}, 32'(set_day), 32'd1);
        check({tag, "_month"}, 32'(set_month), 32'd1);
        check({tag, "_year"}, 32'(set_year), 32'd2020);
        check({tag, "_alarm"}, 32'(alarm_min), 32'd0);
        check({tag, "_pulses"}, {29'd0, set_load, alarm_load, cmd_err}, 32'd0);
        check({tag, "_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;

        clr();
        send_str("3 13 45 07 29 02 24\n", 0);
        check_counts("set1", 1, 0, 0);
        check("set1_notready_cycles", 32'(n_nr), 32'd1);
        check("set1_hour", 32'(set_hour), 32'd13);
        check("set1_min", 32'(set_min), 32'd45);
        check("set1_sec", 32'(set_sec), 32'd7);
        check("set1_day", 32'(set_day), 32'd29);
        check("set1_month", 32'(set_month), 32'd2);
        check("set1_year", 32'(set_year), 32'd2024);

        clr();
        send_str("3 10 00 00 29 02 23\n", 0);
`ifdef CMD_RANGE_CHECK_EN
        check_counts("feb29_2023", 0, 0, 1);
        check("feb29_2023_hour", 32'(set_hour), 32'd13);
        check("feb29_2023_year", 32'(set_year), 32'd2024);
`else
        check_counts("feb29_2023", 1, 0, 0);
        check("feb29_2023_hour", 32'(set_hour), 32'd10);
        check("feb29_2023_day", 32'(set_day), 32'd29);
        check("feb29_2023_year", 32'(set_year), 32'd2023);
`endif

        clr();
        send_str("2\r", 3);
        check("mode_2", 32'(mode), 32'd2);
        send_str("1\n", 2);
        check("mode_1", 32'(mode), 32'd1);
        check_counts("mode", 0, 0, 0);

        clr();
        send_str("4 1439\n", 1);
        check_counts("alarm1439", 0, 1, 0);
        check("alarm1439_val", 32'(alarm_min), 32'd1439);

        clr();
        send_str("4 1440\n", 0);
`ifdef CMD_RANGE_CHECK_EN
        check_counts("alarm1440", 0, 0, 1);
        check("alarm1440_val", 32'(alarm_min), 32'd1439);
`else
        check_counts("alarm1440", 0, 1, 0);
        check("alarm1440_val", 32'(alarm_min), 32'd1440);
`endif

        clr();
        send_str("4 12345\n", 0);
        check_counts("five_digits", 0, 0, 1);
`ifdef CMD_RANGE_CHECK_EN
        check("five_digits_alarm", 32'(alarm_min), 32'd1439);
`else
        check("five_digits_alarm", 32'(alarm_min), 32'd1440);
`endif

        clr();
        send_str("3 1x 00 00 01 01 20\n", 0);
        check_counts("illegal_byte", 0, 0, 1);
        clr();
        send_str("3 01 02 03 04 05 2030\n", 0);
        check_counts("set2", 1, 0, 0);
        check("set2_hour", 32'(set_hour), 32'd1);
        check("set2_day", 32'(set_day), 32'd4);
        check("set2_month", 32'(set_month), 32'd5);
        check("set2_year", 32'(set_year), 32'd2030);

        clr();
        send_str("3 1 2 3\n", 0);
        check_counts("short_count", 0, 0, 1);
        clr();
        send_str("3 0 0 0 1 1 5000\n", 0);
        check_counts("year_4096", 0, 0, 1);
        check("year_4096_keep", 32'(set_year), 32'd2030);
        clr();
        send_str("5\n", 0);
        check_counts("bad_code", 0, 0, 1);
        clr();
        send_str("1 7\n", 0);
        check_counts("mode_with_field", 0, 0, 1);

        send_str("3 12 3", 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b0;
        clr();
        send_str("1\n", 0);
        check("midrst_mode", 32'(mode), 32'd1);
        check_counts("midrst", 0, 0, 0);
        check("midrst_hour", 32'(set_hour), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
